// File: rtl/cam_engine_if.sv
// cam_engine_if -- request/response bundle for the content-addressable memory.
//
// Signals (the requester owns the *_i side, cam_engine owns the *_o side):
//   clear_i                         invalidate every entry
//   read_i / read_index_i           read one entry
//   write_i / write_index_i /
//   write_data_i                    store data into one entry and mark it valid
//   search_i / search_data_i        look up a key across all valid entries
//   read_valid_o / read_hit_o /
//   read_data_o                     read response (valid is a one-cycle pulse)
//   search_valid_o / search_found_o /
//   search_index_o / search_multi_o search response (valid is a one-cycle pulse)
//   occupancy_o                     number of valid entries
//
// Modports: master = requester, slave = cam_engine.

interface cam_engine_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
);
   logic                  clear_i;
   logic                  read_i;
   logic [ADDR_WIDTH-1:0] read_index_i;
   logic                  write_i;
   logic [ADDR_WIDTH-1:0] write_index_i;
   logic [DATA_WIDTH-1:0] write_data_i;
   logic                  search_i;
   logic [DATA_WIDTH-1:0] search_data_i;

   logic                  read_valid_o;
   logic                  read_hit_o;
   logic [DATA_WIDTH-1:0] read_data_o;
   logic                  search_valid_o;
   logic                  search_found_o;
   logic [ADDR_WIDTH-1:0] search_index_o;
   logic                  search_multi_o;
   logic [ADDR_WIDTH:0]   occupancy_o;

   modport master (
      output clear_i, read_i, read_index_i, write_i, write_index_i, write_data_i,
             search_i, search_data_i,
      input  read_valid_o, read_hit_o, read_data_o, search_valid_o, search_found_o,
             search_index_o, search_multi_o, occupancy_o
   );

   modport slave (
      input  clear_i, read_i, read_index_i, write_i, write_index_i, write_data_i,
             search_i, search_data_i,
      output read_valid_o, read_hit_o, read_data_o, search_valid_o, search_found_o,
             search_index_o, search_multi_o, occupancy_o
   );
endinterface

// File: rtl/cam_engine.sv
// cam_engine -- content-addressable memory with DEPTH entries.
//
// Ports:
//   clk_i    single clock, all state changes on its rising edge
//   reset_i  synchronous active-high reset
//   bus      cam_engine_if.slave: clear / read / write / search requests and
//            their responses plus the occupancy count
//
// One request is accepted per cycle with priority clear > read > write > search;
// lower-priority requests in the same cycle are dropped. Reads answer one cycle
// later. Searches run through two register stages (match vector, then encoded
// result), so a new search can start every cycle and results come back in order
// two cycles after acceptance. Data registers are never reset or cleared; only
// the valid bits are.

module cam_engine #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int DEPTH      = 1 << ADDR_WIDTH
) (
   input  logic         clk_i,
   input  logic         reset_i,
   cam_engine_if.slave  bus
);

   localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

   logic [DATA_WIDTH-1:0] data_mem [DEPTH];
   logic [DEPTH-1:0]      valid_reg;
   logic [ADDR_WIDTH:0]   occupancy_reg;

   logic                  read_valid_reg;
   logic                  read_hit_reg;
   logic [DATA_WIDTH-1:0] read_data_reg;

   logic                  s1_valid_reg;
   logic [DEPTH-1:0]      match_vec_reg;
   logic                  search_valid_reg;
   logic                  search_found_reg;
   logic [ADDR_WIDTH-1:0] search_index_reg;
   logic                  search_multi_reg;

   // Request arbitration
   logic do_clear, do_read, do_write, do_search;
   logic read_in_range, write_in_range;

   assign do_clear  = bus.clear_i;
   assign do_read   = !bus.clear_i && bus.read_i;
   assign do_write  = !bus.clear_i && !bus.read_i && bus.write_i;
   assign do_search = !bus.clear_i && !bus.read_i && !bus.write_i && bus.search_i;

   assign read_in_range  = ({1'b0, bus.read_index_i}  < DEPTH_W);
   assign write_in_range = ({1'b0, bus.write_index_i} < DEPTH_W);

   // Parallel compare of the key against every valid entry
   logic [DEPTH-1:0] match_now;
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
      assign match_now[gi] = valid_reg[gi] && (data_mem[gi] == bus.search_data_i);
   end

   // Lowest-index priority encoder on the registered match vector.
   // The downward loop lets the lowest set bit overwrite earlier hits.
   logic                  enc_found;
   logic [ADDR_WIDTH-1:0] enc_index;
   logic                  enc_multi;

   always_comb begin
      enc_found = 1'b0;
      enc_index = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (match_vec_reg[i]) begin
            enc_found = 1'b1;
            enc_index = ADDR_WIDTH'(i);
         end
      end
      // Clearing the lowest set bit leaves something only if two or more matched
      enc_multi = |(match_vec_reg & (match_vec_reg - 1'b1));
   end

   // Data storage: never reset, clears leave contents in place
   always_ff @(posedge clk_i) begin
      if (!reset_i && do_write && write_in_range) begin
         data_mem[bus.write_index_i] <= bus.write_data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         valid_reg        <= '0;
         occupancy_reg    <= '0;
         read_valid_reg   <= 1'b0;
         read_hit_reg     <= 1'b0;
         read_data_reg    <= '0;
         s1_valid_reg     <= 1'b0;
         match_vec_reg    <= '0;
         search_valid_reg <= 1'b0;
         search_found_reg <= 1'b0;
         search_index_reg <= '0;
         search_multi_reg <= 1'b0;
      end else begin
         // Read response; data/hit hold between reads
         read_valid_reg <= do_read;
         if (do_read) begin
            if (read_in_range) begin
               read_hit_reg  <= valid_reg[bus.read_index_i];
               read_data_reg <= data_mem[bus.read_index_i];
            end else begin
               read_hit_reg  <= 1'b0;
               read_data_reg <= '0;
            end
         end

         // Valid bits and occupancy
         if (do_clear) begin
            valid_reg     <= '0;
            occupancy_reg <= '0;
         end else if (do_write && write_in_range) begin
            valid_reg[bus.write_index_i] <= 1'b1;
            if (!valid_reg[bus.write_index_i]) begin
               occupancy_reg <= occupancy_reg + 1'b1;
            end
         end

         // Search stage 1: snapshot of matches, immune to later clears/writes
         s1_valid_reg <= do_search;
         if (do_search) begin
            match_vec_reg <= match_now;
         end

         // Search stage 2: encoded result, held until the next search completes
         search_valid_reg <= s1_valid_reg;
         if (s1_valid_reg) begin
            search_found_reg <= enc_found;
            search_index_reg <= enc_index;
            search_multi_reg <= enc_multi;
         end
      end
   end

   assign bus.read_valid_o   = read_valid_reg;
   assign bus.read_hit_o     = read_hit_reg;
   assign bus.read_data_o    = read_data_reg;
   assign bus.search_valid_o = search_valid_reg;
   assign bus.search_found_o = search_found_reg;
   assign bus.search_index_o = search_index_reg;
   assign bus.search_multi_o = search_multi_reg;
   assign bus.occupancy_o    = occupancy_reg;

endmodule

// File: doc/cam_engine.md
CAM_ENGINE -- requirements
Module: cam_engine

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: entry and key width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5: entry index width.
REQ-003 SHALL have parameter DEPTH, default 1<<ADDR_WIDTH: number of entries; legal range 2..(1<<ADDR_WIDTH).
REQ-004 SHALL have port clk_i, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_i, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port clear_i, input, 1: invalidate all entries.
REQ-007 SHALL have port read_i, input, 1: read request.
REQ-008 SHALL have port read_index_i, input, ADDR_WIDTH: entry to read.
REQ-009 SHALL have port write_i, input, 1: write request.
REQ-010 SHALL have port write_index_i, input, ADDR_WIDTH: entry to write.
REQ-011 SHALL have port write_data_i, input, DATA_WIDTH: data to store.
REQ-012 SHALL have port search_i, input, 1: search request.
REQ-013 SHALL have port search_data_i, input, DATA_WIDTH: search key.
REQ-014 SHALL have port read_valid_o, output, 1: read result valid, one-cycle pulse.
REQ-015 SHALL have port read_hit_o, output, 1: read entry was valid.
REQ-016 SHALL have port read_data_o, output, DATA_WIDTH: read entry contents.
REQ-017 SHALL have port search_valid_o, output, 1: search result valid, one-cycle pulse.
REQ-018 SHALL have port search_found_o, output, 1: at least one valid entry matched.
REQ-019 SHALL have port search_index_o, output, ADDR_WIDTH: lowest matching index.
REQ-020 SHALL have port search_multi_o, output, 1: more than one valid entry matched.
REQ-021 SHALL have port occupancy_o, output, ADDR_WIDTH+1: count of valid entries.

Function
REQ-022 SHALL accept at most one operation per cycle, with priority clear_i > read_i > write_i > search_i; a lower-priority request asserted alongside a higher one is dropped, with no response pulse.
REQ-023 SHALL hold DEPTH entries, each a DATA_WIDTH data register plus a valid bit.
REQ-024 SHALL, on an accepted write, store write_data_i at write_index_i and set its valid bit at that edge; the entry is visible to operations accepted from the next cycle.
REQ-025 SHALL increment occupancy_o on a write to an invalid entry and leave it unchanged on an overwrite of a valid entry.
REQ-026 SHALL, on an accepted clear, drive all valid bits and occupancy_o to 0 at that edge; data registers keep their contents.
REQ-027 SHALL return an accepted read one cycle later: read_valid_o=1, read_data_o=entry data, read_hit_o=entry valid bit.
REQ-028 SHALL run search as a 2-stage pipeline: stage 1 registers a DEPTH-bit match vector (data==key AND valid); stage 2 registers the priority-encoded result; search_valid_o pulses 2 cycles after acceptance.
REQ-029 SHALL accept back-to-back searches every cycle, with results returned in issue order, one per cycle.
REQ-030 SHALL, when no entry matches, drive search_found_o=0, search_index_o=0, search_multi_o=0.
REQ-031 SHALL not let a clear or write accepted after a search's stage 1 alter that search's result.
REQ-032 SHALL treat any access to an index >= DEPTH as a no-op: the write is ignored; the read returns read_valid_o=1, read_hit_o=0, read_data_o=0.
REQ-033 SHALL hold read_data_o and the search result outputs at their last values when the corresponding valid output is 0.

Reset
REQ-034 SHALL, while reset_i is high at a rising edge, clear all valid bits, occupancy_o, read_valid_o, read_hit_o, read_data_o, search_valid_o, search_found_o, search_index_o, search_multi_o and both pipeline stages to 0.
REQ-035 SHALL discard in-flight searches and requests arriving during reset; no response pulse follows reset release.

Verification
REQ-036 Write 0xDEADBEEF@3, then search key 0xDEADBEEF the next cycle -> 2 cycles later search_valid_o=1, found=1, index=3, multi=0; occupancy_o=1.
REQ-037 Write 0x55@7 and 0x55@2, then search 0x55 -> found=1, index=2, multi=1; occupancy_o=2.
REQ-038 Read, write and search all asserted in one cycle -> only the read is serviced: read_valid_o pulses next cycle, occupancy_o unchanged, no search_valid_o.
REQ-039 Fill all 32 entries, overwrite entry 0, then clear -> occupancy_o reads 32 after filling, stays 32 after the overwrite, goes to 0 after the clear; a search for the old entry 0 value then returns found=0.
REQ-040 Four back-to-back searches (hit@1, miss, hit@4, miss) -> four consecutive search_valid_o pulses with found=1/0/1/0 and index=1/0/4/0.
REQ-041 Issue a search, assert reset_i in the next cycle -> no search_valid_o appears; all outputs are 0 after reset release.
